// File: rtl/pixel_sensor_control.sv
// Frame sequencer for the pixel array: ERASE, EXPOSE, RAMP/COUNTER, row READ.
// Optional macro PIXEL_COUNTER_GRAY_EN drives COUNTER as Gray code.
module pixel_sensor_control #(
    parameter int PIXEL_BITS         = 8,
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int ERASE_CYCLES       = 5,
    parameter int EXPOSE_CYCLES      = 255,
    parameter int READ_CYCLES        = 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          START,
    input  logic                          CONTINUOUS,
    output logic                          ERASE,
    output logic                          EXPOSE,
    output logic                          RAMP,
    output logic [PIXEL_BITS-1:0]         COUNTER,
    output logic [PIXEL_ARRAY_HEIGHT-1:0] READ,
    output logic                          BUSY,
    output logic                          FRAME_DONE
);

    localparam int MAX_EX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int MAX_D  = (MAX_EX > READ_CYCLES) ? MAX_EX : READ_CYCLES;
    localparam int DW     = (MAX_D > 1) ? $clog2(MAX_D) : 1;
    localparam int RW     = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

    localparam logic [DW-1:0] ERASE_LOAD  = DW'(ERASE_CYCLES - 1);
    localparam logic [DW-1:0] EXPOSE_LOAD = DW'(EXPOSE_CYCLES - 1);
    localparam logic [DW-1:0] READ_LOAD   = DW'(READ_CYCLES - 1);
    localparam logic [RW-1:0] LAST_ROW    = RW'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [PIXEL_BITS-1:0] BIN_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    state_t                  state, state_n;
    logic [DW-1:0]           dur, dur_n;
    logic [RW-1:0]           row, row_n;
    logic [PIXEL_BITS-1:0]   bin, bin_n;
    logic [PIXEL_BITS-1:0]   code_n;
    logic [PIXEL_ARRAY_HEIGHT-1:0] read_n;
    logic                    done_n;

    // State, duration counter, row index and conversion count registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
            dur   <= '0;
            row   <= '0;
            bin   <= '0;
        end else begin
            state <= state_n;
            dur   <= dur_n;
            row   <= row_n;
            bin   <= bin_n;
        end
    end

    // Next-state logic; the duration counter is reloaded on each state entry
    always_comb begin
        state_n = state;
        dur_n   = (dur != '0) ? dur - DW'(1) : dur;
        row_n   = row;
        bin_n   = bin;
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    state_n = S_ERASE;
                    dur_n   = ERASE_LOAD;
                    bin_n   = '0;
                end
            end
            S_ERASE: begin
                if (dur == '0) begin
                    state_n = S_EXPOSE;
                    dur_n   = EXPOSE_LOAD;
                end
            end
            S_EXPOSE: begin
                if (dur == '0) begin
                    state_n = S_CONVERT;
                    bin_n   = '0;
                end
            end
            S_CONVERT: begin
                if (bin == BIN_MAX) begin
                    state_n = S_READ;
                    row_n   = '0;
                    dur_n   = READ_LOAD;
                end else begin
                    bin_n = bin + PIXEL_BITS'(1);
                end
            end
            S_READ: begin
                if (dur == '0) begin
                    if (row == LAST_ROW) begin
                        bin_n = '0;
                        row_n = '0;
                        if (CONTINUOUS) begin
                            state_n = S_ERASE;
                            dur_n   = ERASE_LOAD;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        row_n = row + RW'(1);
                        dur_n = READ_LOAD;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output is a flop
    always_comb begin
        read_n = '0;
        if (state_n == S_READ) begin
            read_n = PIXEL_ARRAY_HEIGHT'(1) << row_n;
        end
        done_n = (state_n == S_READ) && (row_n == LAST_ROW) && (dur_n == '0);
`ifdef PIXEL_COUNTER_GRAY_EN
        code_n = bin_n ^ (bin_n >> 1);
`else
        code_n = bin_n;
`endif
    end

    // Registered pixel-array outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ERASE      <= 1'b0;
            EXPOSE     <= 1'b0;
            RAMP       <= 1'b0;
            COUNTER    <= '0;
            READ       <= '0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            ERASE      <= (state_n == S_ERASE);
            EXPOSE     <= (state_n == S_EXPOSE);
            RAMP       <= (state_n == S_CONVERT);
            COUNTER    <= code_n;
            READ       <= read_n;
            BUSY       <= (state_n != S_IDLE);
            FRAME_DONE <= done_n;
        end
    end

endmodule

// File: tb/tb_pixel_sensor_control.sv
// Directed bench for pixel_sensor_control with a frame-position model.
// Honours PIXEL_COUNTER_GRAY_EN like the design.
module tb_pixel_sensor_control;

    localparam int PB = 4;
    localparam int H  = 2;
    localparam int EC = 2;
    localparam int XC = 3;
    localparam int RC = 2;
    localparam int CC = 1 << PB;
    localparam int FL = EC + XC + CC + H * RC;
    localparam int VW = PB + H + 5;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          START = 1'b0;
    logic          CONTINUOUS = 1'b0;
    logic          ERASE, EXPOSE, RAMP, BUSY, FRAME_DONE;
    logic [PB-1:0] COUNTER;
    logic [H-1:0]  READ;

    int vectors = 0;
    int miscompares = 0;
    int pos = -1;
    int cy = 0;
    bit chk_en = 1'b0;
    logic [PB-1:0] conv_tab [CC];

    pixel_sensor_control #(
        .PIXEL_BITS(PB),
        .PIXEL_ARRAY_HEIGHT(H),
        .ERASE_CYCLES(EC),
        .EXPOSE_CYCLES(XC),
        .READ_CYCLES(RC)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .START(START),
        .CONTINUOUS(CONTINUOUS),
        .ERASE(ERASE),
        .EXPOSE(EXPOSE),
        .RAMP(RAMP),
        .COUNTER(COUNTER),
        .READ(READ),
        .BUSY(BUSY),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    // Expected outputs from position within the frame (-1 = idle)
    function automatic logic [VW-1:0] expect_vec(int p);
        logic e, x, r, b, d;
        logic [PB-1:0] c;
        logic [H-1:0] rd;
        int cnt;
        e = 0; x = 0; r = 0; b = 0; d = 0; rd = '0; cnt = 0;
        if (p >= 0) begin
            b = 1;
            if (p < EC) e = 1;
            else if (p < EC + XC) x = 1;
            else if (p < EC + XC + CC) begin
                r = 1;
                cnt = p - (EC + XC);
            end else begin
                cnt = CC - 1;
                rd = H'(1) << ((p - (EC + XC + CC)) / RC);
            end
            d = (p == FL - 1);
        end
        c = PB'(cnt);
`ifdef PIXEL_COUNTER_GRAY_EN
        c = c ^ (c >> 1);
`endif
        return {e, x, r, c, rd, b, d};
    endfunction

    // Model advance on each edge, then compare just after it
    always @(posedge CLK) begin
        logic [VW-1:0] got, exp;
        if (RESET) pos = -1;
        else if (pos < 0) begin
            if (START) pos = 0;
        end else if (pos == FL - 1) pos = CONTINUOUS ? 0 : -1;
        else pos++;
        #1;
        if (chk_en) begin
            got = {ERASE, EXPOSE, RAMP, COUNTER, READ, BUSY, FRAME_DONE};
            exp = expect_vec(pos);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL model t=%0t: got %h expected %h (pos %0d)",
                         $time, got, exp, pos);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge CLK);
            cy++;
        end
    endtask

    task automatic launch();
        START = 1'b1;
        cy = 0;
        step();
        START = 1'b0;
    endtask

    initial begin
`ifdef PIXEL_COUNTER_GRAY_EN
        conv_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
`else
        for (int i = 0; i < CC; i++) conv_tab[i] = PB'(i);
`endif
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
        chk_en = 1'b1;
        chk("reset_state", 32'({ERASE, EXPOSE, RAMP, COUNTER, READ, BUSY, FRAME_DONE}), 32'h0);
        step(20);
        chk("idle_20", 32'({ERASE, EXPOSE, RAMP, COUNTER, READ, BUSY, FRAME_DONE}), 32'h0);

        // single frame, literal timeline
        launch();
        chk("c1_erase", 32'({ERASE, EXPOSE, BUSY}), 32'b101);
        step();
        chk("c2_erase", 32'({ERASE, EXPOSE}), 32'b10);
        step();
        chk("c3_expose", 32'({ERASE, EXPOSE, RAMP}), 32'b010);
        step(2);
        chk("c5_expose", 32'({EXPOSE, RAMP}), 32'b10);
        step();
        chk("c6_ramp", 32'({EXPOSE, RAMP}), 32'b01);
        for (int i = 0; i < CC; i++) begin
            chk("conv_code", 32'(COUNTER), 32'(conv_tab[i]));
            if (i < CC - 1) step();
        end
        step();
        chk("c22_read0", 32'({RAMP, READ, FRAME_DONE}), 32'b0010);
        step();
        chk("c23_read0", 32'({READ, FRAME_DONE}), 32'b010);
        step();
        chk("c24_read1", 32'({READ, FRAME_DONE}), 32'b100);
        chk("c24_hold", 32'(COUNTER), 32'(conv_tab[CC-1]));
        step();
        chk("c25_done", 32'({READ, FRAME_DONE, BUSY}), 32'b1011);
        step();
        chk("c26_idle", 32'({BUSY, COUNTER, READ, FRAME_DONE}), 32'h0);
        step(3);

        // continuous frames
        CONTINUOUS = 1'b1;
        launch();
        step(24);
        chk("cont_done1", 32'(FRAME_DONE), 32'h1);
        step();
        chk("cont_c26", 32'({ERASE, BUSY, COUNTER}), 32'({2'b11, 4'h0}));
        step(4);
        CONTINUOUS = 1'b0;
        step(20);
        chk("cont_done2", 32'({FRAME_DONE, READ}), 32'b110);
        step();
        chk("cont_end", 32'(BUSY), 32'h0);
        step(5);

        // reset in the middle of conversion
        launch();
        step(12);
        chk("mid_cnt7", 32'(COUNTER), 32'(conv_tab[7]));
        RESET = 1'b1;
        step();
        chk("mid_reset", 32'({ERASE, EXPOSE, RAMP, COUNTER, READ, BUSY, FRAME_DONE}), 32'h0);
        RESET = 1'b0;
        step(3);
        launch();
        step(30);

        // start pulses while busy are dropped
        launch();
        step(3);
        START = 1'b1;
        step();
        START = 1'b0;
        step(18);
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        chk("busy_done", 32'(FRAME_DONE), 32'h1);
        step();
        chk("busy_idle", 32'(BUSY), 32'h0);
        step(5);
        chk("busy_noqueue", 32'(BUSY), 32'h0);

        // start held high across several frames
        START = 1'b1;
        step(60);
        START = 1'b0;
        step(30);

        // reset beats start in the same cycle
        START = 1'b1;
        RESET = 1'b1;
        step();
        START = 1'b0;
        RESET = 1'b0;
        chk("reset_wins", 32'({ERASE, BUSY}), 32'h0);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
